// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 data mux select path.
// Provides the requester count, select width, the select type and the
// arbiter state encoding used by rr_sel_arbiter and rr_pick4.
package mux_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Scans upward from (last+1) mod 4 with wrap-around and returns the first
// requesting channel, so the channel in 'last' has the lowest priority.
// Ports:
//   req    - per-requester request, bit i = channel i
//   last   - most recently served channel
//   winner - chosen channel (holds 'last' when nothing requests)
//   any    - at least one request is present
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = last;
    idx    = last;
    any    = |req;
    // Walk from the farthest candidate (last itself) down to last+1, so the
    // nearest requesting channel is the one that sticks.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + sel_t'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the 4:1 data mux.
// A winner keeps the mux for up to HOLD_CYCLES accepted transfers or until
// it drops its request; then one idle cycle passes and the next requester
// in rotation is chosen. All outputs are registered.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   req       - per-requester request, bit i = channel i
//   out_ready - consumer accepts the current muxed sample
//   sel       - mux select code (00 = ch0 .. 11 = ch3)
//   gnt       - one-hot grant, zero when idle
//   out_valid - sel/gnt valid and the mux output is a live sample
module rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid
);

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [SEL_W-1:0] last;

  logic [SEL_W-1:0]   winner;
  logic               any;
  logic [NUM_REQ-1:0] winner_oh;
  logic               xfer;
  logic               drop;
  logic               release_now;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    winner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    xfer        = out_valid && out_ready;
    // Dropping the request releases even under backpressure; the pending
    // sample is simply abandoned.
    drop        = !req[sel];
    release_now = drop || (xfer && (hold_cnt == HoldLast));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      hold_cnt  <= '0;
      last      <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            sel       <= winner;
            gnt       <= winner_oh;
            out_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            last      <= sel;
            gnt       <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            state     <= IDLE;
          end else if (xfer) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
          // Otherwise backpressured: everything holds, no timeout.
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          out_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed vectors with literal expectations plus
// a behavioural round-robin model compared on every falling edge.
module tb_rr_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_xfers = 0;
  int m_last  = 3;
  int m_sel   = 0;
  bit model_ok = 1'b0;

  rr_sel_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: one call per clock edge with the inputs present at that edge.
  task automatic model_edge(input bit r, input logic [3:0] q, input bit rdy);
    if (r) begin
      m_busy  = 1'b0;
      m_sel   = 0;
      m_xfers = 0;
      m_last  = 3;
    end else if (!m_busy) begin
      if (q != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (q[c] && !m_busy) begin
            m_busy  = 1'b1;
            m_owner = c;
            m_sel   = c;
            m_xfers = 0;
          end
        end
      end
    end else begin
      bit done;
      done = 1'b0;
      if (!q[m_owner]) begin
        done = 1'b1;
      end else if (rdy) begin
        m_xfers++;
        if (m_xfers == HOLD) done = 1'b1;
      end
      if (done) begin
        m_busy  = 1'b0;
        m_last  = m_owner;
        m_xfers = 0;
      end
    end
  endtask

  task automatic step(input bit r, input logic [3:0] q, input bit rdy);
    rst       = r;
    req       = q;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r, q, rdy);
    model_ok = 1'b1;
    #1;
  endtask

  task automatic expect_out(input string nm, input int s, input int g, input int v);
    chk({nm, ".sel"}, int'(sel), s);
    chk({nm, ".gnt"}, int'(gnt), g);
    chk({nm, ".valid"}, int'(out_valid), v);
  endtask

  // Per-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model.sel", int'(sel), m_sel);
      chk("model.gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
      chk("model.valid", int'(out_valid), int'(m_busy));
      chk("inv.onehot0", int'($onehot0(gnt)), 1);
      chk("inv.gnt_sel", int'(gnt), out_valid ? (1 << sel) : 0);
    end
  end

  initial begin
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;

    // Reset then idle
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    expect_out("reset", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0000, 1'b1);
      expect_out("idle", 0, 0, 0);
    end

    // Single requester: 4 transfers, one bubble, regrant ch2
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      if (i == 4) expect_out("single_bubble", 2, 0, 0);
      else        expect_out("single", 2, 4, 1);
    end

    // Full rotation from reset
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 21; i++) begin
      int s;
      int v;
      step(1'b0, 4'b1111, 1'b1);
      s = (i / 5) % 4;
      v = (i % 5 != 4) ? 1 : 0;
      expect_out("rotate", s, v ? (1 << s) : 0, v);
    end

    // Backpressure on ch1, then exactly 4 accepted transfers
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    expect_out("bp_grant", 1, 2, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0010, 1'b0);
      expect_out("bp_hold", 1, 2, 1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0010, 1'b1);
      if (i < 3) expect_out("bp_xfer", 1, 2, 1);
      else       expect_out("bp_release", 1, 0, 0);
    end

    // Early drop on ch3 (under backpressure) and wrap to ch0
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b1);
    expect_out("drop_grant", 3, 8, 1);
    step(1'b0, 4'b1011, 1'b1);
    expect_out("drop_xfer", 3, 8, 1);
    step(1'b0, 4'b0011, 1'b0);
    expect_out("drop_release", 3, 0, 0);
    step(1'b0, 4'b0011, 1'b1);
    expect_out("wrap_ch0", 0, 1, 1);

    // Reset mid-grant
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    expect_out("mid_grant", 2, 4, 1);
    step(1'b1, 4'b1111, 1'b1);
    expect_out("mid_reset", 0, 0, 0);
    step(1'b0, 4'b1111, 1'b1);
    expect_out("post_reset", 0, 1, 1);

    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's 4:1 data mux and drives its 2-bit sel.
- Four requesters compete. The winner holds sel for up to HOLD_CYCLES accepted transfers, or until it drops its request.
- Grant is then passed to the next requester in rotation.
- A valid/ready pair tells the consumer when the muxed output is meaningful.

Parameters:
- NUM_REQ, 4: number of requesters; fixed at 4 to match the 4:1 mux.
- SEL_W, 2: select width, log2(NUM_REQ).
- HOLD_CYCLES, 4: maximum accepted transfers per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester request; bit i = channel i.
- out_ready  input  1  consumer accepts the current muxed sample.
- sel  output  SEL_W  select code to the mux; 2'b00=ch0 … 2'b11=ch3.
- gnt  output  NUM_REQ  one-hot grant; all zero when idle.
- out_valid  output  1  sel/gnt are valid and the mux output is a live sample.

Behaviour:
- Reset: clk and rst only; synchronous, active-high. On a clk edge with rst=1: state=IDLE, sel=2'b00, gnt=4'b0000, out_valid=0, hold_cnt=0, last=2'b11. Reset has priority over all other events, including mid-grant; outputs clear on that same edge.
- All outputs are registered.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, remain in IDLE with outputs unchanged (sel holds its last value; gnt=0; out_valid=0).
  - Otherwise pick the first set bit scanning (last+1) mod 4 upward with wrap-around.
  - Next edge: sel=winner, gnt=1<<winner, out_valid=1, hold_cnt=0, state=GRANT.
  - Request-to-grant latency: 1 cycle.
- GRANT:
  - A transfer occurs on any edge where out_valid && out_ready; hold_cnt increments on each transfer.
  - Release condition A: a transfer occurs with hold_cnt==HOLD_CYCLES-1.
  - Release condition B: req[sel]==0. This applies regardless of out_ready, and an unaccepted sample is dropped.
  - If A and B coincide, release once.
  - On release, next edge: last=sel, gnt=0, out_valid=0, hold_cnt=0, state=IDLE; sel holds.
  - After release there is one idle bubble, so the next grant appears 2 edges after the releasing edge.
  - While out_valid && !out_ready && req[sel]==1: sel, gnt and hold_cnt are frozen. This is backpressure with no timeout.
- Fairness: a requester that just released has lowest priority on the next arbitration. With all four requesting continuously, grants rotate 0,1,2,3,0…
- Requests from other channels during GRANT are ignored until release.
- hold_cnt width is 4 bits; it never wraps, since release occurs at HOLD_CYCLES-1.
- HOLD_CYCLES=1: exactly one transfer per grant.
- Invariants, for the bench to assert: gnt==0 whenever out_valid==0; gnt==1<<sel whenever out_valid==1; $onehot0(gnt) always.

Decomposition:
- Shared package (mux_pkg):
  - localparams NUM_REQ=4, SEL_W=2.
  - typedef logic [SEL_W-1:0] sel_t.
  - enum state_t {IDLE, GRANT}.
- One natural sub-module: rr_pick4. It is combinational and takes req[3:0] and last[1:0], returning winner[1:0] and any. It is reusable for other round-robin points in the datapath.
- FSM, hold counter and output registers live in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0000 for 5 cycles -> sel=00, gnt=0000, out_valid=0 throughout.
- Single requester: req=0100, out_ready=1 -> 1 cycle later sel=10, gnt=0100, out_valid=1. After 4 transfers, release for 1 cycle (out_valid=0), then regrant ch2.
- Full rotation: req=1111, out_ready=1, HOLD_CYCLES=4 -> sel sequence 00×4, bubble, 01×4, bubble, 10×4, bubble, 11×4, bubble, 00…
- Backpressure: grant ch1, out_ready=0 for 6 cycles -> sel=01, hold_cnt frozen at 0. Release ready -> exactly 4 accepted transfers before release.
- Early drop and wrap: grant ch3, deassert req[3] after 1 transfer while req=0011 -> release next edge; next grant goes to ch0 (wrap from last=3), not ch1.
- Reset mid-grant: rst=1 while out_valid=1, sel=10 -> next edge gnt=0, out_valid=0, sel=00. With req=1111 after reset, first grant is ch0.
